fp_addsub_seq: RTL

Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor for the 16-bit MIPS datapath. It replaces the combinational half-precision adder and adds subtraction, round-to-nearest-even, special-value handling, status flags and a valid/ready handshake. It sits behind the FPU issue stage and takes one operation at a time. The default parameters give binary16.

---
 rtl/fp_addsub_seq.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-style floating-point adder/subtractor.
// Round-to-nearest-even, subnormals flushed on input and output, status flags.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The input side accepts only in IDLE (in_ready = state is IDLE). The
// output side holds result/flags/out_valid stable until out_ready is seen high
// while out_valid is high. After that, the block returns to IDLE.
module fp_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags,
  output logic [2:0]           state_dbg
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden bit, fraction, guard, round, sticky
  localparam int EW = EXP_W + 2;  // signed working exponent
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] D_MAX    = EXP_W'(SW - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           op_q, op_d;
  logic [SW-1:0]  x_q, x_d, y_q, y_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic           sx_q, sx_d, sub_q, sub_d;
  logic           spec_q, spec_d;
  logic [W-1:0]   spec_res_q, spec_res_d;
  logic [3:0]     spec_flg_q, spec_flg_d;
  logic [SW:0]    sum_q, sum_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic           out_valid_q, out_valid_d;

  // Leading-zero count of the non-carry part of the sum.
  function automatic logic [EW-1:0] lzc(input logic [SW-1:0] v);
    logic [EW-1:0] n;
    n = EW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) n = EW'(SW - 1 - i);
    end
    return n;
  endfunction

  // Unpack, order by magnitude, align the smaller operand, classify specials.
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] fa, fb, fa_z, fb_z, fx, fy;
  logic             sa, sb, sxa, sya, swap, y_st;
  logic [SW-1:0]    sig_x, sig_y, y_sh, y_lost, y_al;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, spec_c;
  logic [W-1:0]     spec_res_c;
  logic [3:0]       spec_flg_c;
  always_comb begin
    ea   = a_q[W-2:MAN_W];
    eb   = b_q[W-2:MAN_W];
    fa   = a_q[MAN_W-1:0];
    fb   = b_q[MAN_W-1:0];
    sa   = a_q[W-1];
    sb   = b_q[W-1] ^ op_q;
    fa_z = (ea == '0) ? '0 : fa;
    fb_z = (eb == '0) ? '0 : fb;
    swap = {eb, fb_z} > {ea, fa_z};
    ex   = swap ? eb : ea;
    ey   = swap ? ea : eb;
    fx   = swap ? fb_z : fa_z;
    fy   = swap ? fa_z : fb_z;
    sxa  = swap ? sb : sa;
    sya  = swap ? sa : sb;
    sig_x = (ex == '0) ? '0 : {1'b1, fx, 3'b000};
    sig_y = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
    d     = ex - ey;
    if (d > D_MAX) begin
      y_sh   = '0;
      y_lost = sig_y;
    end else begin
      {y_sh, y_lost} = {sig_y, {SW{1'b0}}} >> d;
    end
    y_st = |y_lost;
    y_al = y_sh | {{(SW-1){1'b0}}, y_st};

    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    spec_c = a_nan | b_nan | a_inf | b_inf;
    spec_res_c = QNAN;
    spec_flg_c = 4'b0000;
    if (a_nan || b_nan) begin
      spec_flg_c = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_flg_c = 4'b1000;
    end else if (a_inf) begin
      spec_res_c = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res_c = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // Magnitude add or subtract; X >= Y is guaranteed by the swap.
  logic [SW:0] sum_c;
  always_comb begin
    sum_c = sub_q ? ({1'b0, x_q} - {1'b0, y_q}) : ({1'b0, x_q} + {1'b0, y_q});
  end

  // Normalise, round to nearest even, and pick the final result class.
  logic [EW-1:0]    e_ext, en, ef, lz;
  logic [SW-1:0]    m;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac_c;
  logic             rup, inex;
  logic [W-1:0]     res_c;
  logic [3:0]       flg_c;
  always_comb begin
    e_ext = {2'b00, e_q};
    lz    = '0;
    if (sum_q[SW]) begin
      m  = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      en = e_ext + EW'(1);
    end else begin
      lz = lzc(sum_q[SW-1:0]);
      m  = sum_q[SW-1:0] << lz;
      en = e_ext - lz;
    end
    inex = m[2] | m[1] | m[0];
    rup  = m[2] & (m[1] | m[0] | m[3]);
    mr   = {1'b0, m[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    if (mr[MAN_W+1]) begin
      ef     = en + EW'(1);
      frac_c = mr[MAN_W:1];
    end else begin
      ef     = en;
      frac_c = mr[MAN_W-1:0];
    end
    if (spec_q) begin
      res_c = spec_res_q;
      flg_c = spec_flg_q;
    end else if (sum_q == '0) begin
      res_c = {sub_q ? 1'b0 : sx_q, {(W-1){1'b0}}};
      flg_c = 4'b0000;
    end else if (!ef[EW-1] && (ef >= {2'b00, EXP_ONES})) begin
      res_c = {sx_q, EXP_ONES, {MAN_W{1'b0}}};
      flg_c = 4'b0101;
    end else if (ef[EW-1] || (ef == '0)) begin
      res_c = {sx_q, {(W-1){1'b0}}};
      flg_c = 4'b0011;
    end else begin
      res_c = {sx_q, ef[EXP_W-1:0], frac_c};
      flg_c = {3'b000, inex};
    end
  end

  // FSM next-state and register loads, one pipeline step per state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    e_d         = e_q;
    sx_d        = sx_q;
    sub_d       = sub_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    spec_flg_d  = spec_flg_q;
    sum_d       = sum_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        x_d        = sig_x;
        y_d        = y_al;
        e_d        = ex;
        sx_d       = sxa;
        sub_d      = sxa ^ sya;
        spec_d     = spec_c;
        spec_res_d = spec_res_c;
        spec_flg_d = spec_flg_c;
        state_d    = S_ADD;
      end
      S_ADD: begin
        sum_d   = sum_c;
        state_d = S_NORM;
      end
      S_NORM: begin
        result_d = res_c;
        flags_d  = flg_c;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // out_valid is raised one edge after entering DONE for a fixed 4-edge latency.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      e_q         <= '0;
      sx_q        <= 1'b0;
      sub_q       <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      spec_flg_q  <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      e_q         <= e_d;
      sx_q        <= sx_d;
      sub_q       <= sub_d;
      spec_q      <= spec_d;
      spec_res_q  <= spec_res_d;
      spec_flg_q  <= spec_flg_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign state_dbg = state_q;

endmodule
